// File: rtl/dp_pkg.sv
// Shared datapath definitions: status-flag bit positions and a constant log2 helper.
package dp_pkg;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_W     = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers; head is readable with zero latency.
// A new entry appears one cycle after the push edge; the push is ignored when full and the pop is ignored when empty.
module sync_fifo
  import dp_pkg::*;
#(
  parameter int W     = 19,
  parameter int DEPTH = 8,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Empty reads 0 so the consumer never sees stale storage.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/dp_result_fifo.sv
// Flags each datapath result {carry,neg,zero} and buffers it; head visible 1 cycle after push.
// in_ready = !full (independent of out_ready); offers made while full are dropped and counted.
module dp_result_fifo
  import dp_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  localparam int LW   = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [N-1:0]      in_y,
  input  logic              in_co,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_y,
  output logic [FLAG_W-1:0] out_flags,
  output logic [LW-1:0]     level,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  total_cnt
);

  logic [FLAG_W-1:0]   in_flags;
  logic [N+FLAG_W-1:0] rdata;
  logic                full, empty, push, pop;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]    total_cnt_q, total_cnt_d;

  always_comb begin
    in_flags             = '0;
    in_flags[FLAG_ZERO]  = (in_y == '0);
    in_flags[FLAG_NEG]   = in_y[N-1];
    in_flags[FLAG_CARRY] = in_co;
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .W     (N + FLAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_flags, in_y}),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign out_y     = rdata[N-1:0];
  assign out_flags = rdata[N +: FLAG_W];

  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    total_cnt_d = total_cnt_q;
    if (in_valid && !in_ready && (drop_cnt_q != '1)) drop_cnt_d  = drop_cnt_q + CNT_W'(1);
    if (push && (total_cnt_q != '1))                 total_cnt_d = total_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q  <= '0;
      total_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      total_cnt_q <= total_cnt_d;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign total_cnt = total_cnt_q;

endmodule
